// File: rtl/mux_n_scan_if.sv
// Output-side bus of mux_n_scan: registered sample, its channel index and
// status flags, with a valid/ready handshake.
interface mux_n_scan_if #(
  parameter int N = 8,
  parameter int W = 1,
  parameter int S = $clog2(N)
);
  logic [W-1:0] y;
  logic [S-1:0] sel_out;
  logic         valid;
  logic         ready;
  logic         wrap;
  logic         sel_err;

  modport master (output y, sel_out, valid, wrap, sel_err, input ready);
  modport slave  (input y, sel_out, valid, wrap, sel_err, output ready);
endinterface

// File: rtl/mux_n_scan.sv
// N-channel, W-bit registered mux with manual select and round-robin scan modes.
// Optional MUX_N_SCAN_MASK_EN adds a per-channel mask that scan mode skips over.
module mux_n_scan #(
  parameter int N = 8,
  parameter int W = 1,
  parameter int S = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             mode,
  input  logic [S-1:0]     sel_in,
  input  logic [N*W-1:0]   a,
`ifdef MUX_N_SCAN_MASK_EN
  input  logic [N-1:0]     mask,
`endif
  mux_n_scan_if.master     bus
);

  logic [S-1:0] ptr;
  logic [S-1:0] scan_ch;
  logic [S-1:0] scan_next;
  logic         scan_hit;
  logic         scan_wrap;
  logic [W-1:0] man_data;
  logic [W-1:0] scan_data;
  logic         sel_ok;
  logic         load;

`ifdef MUX_N_SCAN_MASK_EN
  localparam int unsigned NU = N;

  // Nearest enabled channel at or after ptr in circular order; wrap marks the
  // highest enabled channel, since the next search must come round through 0.
  always_comb begin
    int unsigned best;
    int unsigned d;
    logic        above;
    scan_ch  = ptr;
    scan_hit = 1'b0;
    best     = NU;
    d        = '0;
    above    = 1'b0;
    for (int unsigned k = 0; k < NU; k++) begin
      d = (k >= 32'(ptr)) ? k - 32'(ptr) : k + NU - 32'(ptr);
      if (mask[k] && d < best) begin
        best     = d;
        scan_ch  = S'(k);
        scan_hit = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NU; k++) begin
      if (mask[k] && S'(k) > scan_ch) above = 1'b1;
    end
    scan_wrap = !above;
  end
`else
  always_comb begin
    scan_ch   = ptr;
    scan_hit  = 1'b1;
    scan_wrap = (ptr == S'(N - 1));
  end
`endif

  assign scan_next = (scan_ch == S'(N - 1)) ? '0 : scan_ch + 1'b1;
  assign sel_ok    = (32'(sel_in) < 32'(N));

  // Out-of-range manual selects match no channel and yield zero.
  always_comb begin
    man_data  = '0;
    scan_data = '0;
    for (int unsigned k = 0; k < 32'(N); k++) begin
      if (sel_in == S'(k))  man_data  = a[k*W +: W];
      if (scan_ch == S'(k)) scan_data = a[k*W +: W];
    end
  end

  assign load = ena && (!bus.valid || bus.ready) && (!mode || scan_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.y       <= '0;
      bus.sel_out <= '0;
      bus.valid   <= 1'b0;
      bus.wrap    <= 1'b0;
      bus.sel_err <= 1'b0;
      ptr         <= '0;
    end else if (load) begin
      bus.valid <= 1'b1;
      if (mode) begin
        bus.y       <= scan_data;
        bus.sel_out <= scan_ch;
        bus.wrap    <= scan_wrap;
        bus.sel_err <= 1'b0;
        ptr         <= scan_next;
      end else begin
        bus.y       <= man_data;
        bus.sel_out <= sel_in;
        bus.wrap    <= 1'b0;
        bus.sel_err <= !sel_ok;
      end
    end else if (bus.valid && bus.ready) begin
      bus.valid   <= 1'b0;
      bus.wrap    <= 1'b0;
      bus.sel_err <= 1'b0;
    end
  end

endmodule

// File: doc/mux_n_scan.md
# mux_n_scan

Parametrised N-channel, W-bit registered multiplexer with an output valid/ready handshake. It generalises the combinational 8:1 single-bit mux. A manual mode registers the channel selected by `sel_in`. A scan mode steps round-robin through all channels, presenting one sample per accepted transfer. The block sits between a bank of sensor/status inputs and a single serial consumer (logger, UART formatter) that cannot accept data every cycle.

## Interface
Parameters:
- `N`, 8: number of input channels, N ≥ 2, not required to be a power of two.
- `W`, 1: width of each channel in bits, W ≥ 1.
- `S`, `$clog2(N)`: select width (derived; do not override).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ena`  in  1  capture enable; no new sample when low.
- `mode`  in  1  0 = manual select, 1 = round-robin scan.
- `sel_in`  in  S  channel index used in manual mode.
- `a`  in  N*W  packed channel data; channel k occupies `a[k*W +: W]`.
- `y`  out  W  registered sample data.
- `sel_out`  out  S  channel index that produced `y`.
- `valid`  out  1  `y`/`sel_out` hold an unconsumed sample.
- `ready`  in  1  consumer accepts the sample when `valid && ready`.
- `wrap`  out  1  high with a scan-mode sample from the last channel of a sweep.
- `sel_err`  out  1  high with a manual-mode sample whose `sel_in` ≥ N.

## Operation
- Load condition: `load = ena && (!valid || ready)`. Outputs change only on `load` or `rst`.
- Reset (`rst` high at an edge, overriding everything):
  - `y`=0, `sel_out`=0, `valid`=0, `wrap`=0, `sel_err`=0.
  - Scan pointer `ptr`=0.
- Manual mode (`mode`=0), on load:
  - If `sel_in` < N: `y`←channel `sel_in`, `sel_err`←0.
  - If `sel_in` ≥ N: `y`←0, `sel_err`←1.
  - In both cases: `sel_out`←`sel_in`, `valid`←1, `wrap`←0.
  - `ptr` is unchanged.
- Scan mode (`mode`=1), on load:
  - `y`←channel `ptr`, `sel_out`←`ptr`, `valid`←1, `sel_err`←0.
  - `wrap`←(`ptr`==N−1).
  - `ptr`←(`ptr`==N−1) ? 0 : `ptr`+1. The pointer wraps at N−1, never at 2^S−1.
- No load and `valid && ready`: `valid`←0, `wrap`←0, `sel_err`←0. The sample has been consumed and nothing replaces it.
- No load and `valid && !ready`: all outputs hold (backpressure). Data, `sel_out`, and flags stay stable until accepted.
- Simultaneous accept and load (`valid && ready && ena`): the new sample replaces the old one in the same edge. `valid` stays 1, with no bubble.
- Mode change takes effect at the next load. `ptr` is retained across manual periods, so scanning resumes where it stopped.
- `a` is sampled only at the load edge. Changes to `a` while a sample is held do not affect `y`.

## Timing
- Latency: one cycle from the load edge to `y`/`valid` visible.
- Throughput: one sample per cycle when `ready` is held high and `ena` is high.
- Scan sweep: N accepted transfers visit channels 0..N−1 in order. `wrap` marks the Nth transfer.
- `ready` may be combinationally dependent on `valid` downstream. No output is combinationally dependent on `ready`; all outputs are registered.
- `rst` asserted mid-sweep or mid-stall: the next edge clears `valid` and `ptr`. The held sample is dropped.

## Configuration
- `MUX_N_SCAN_MASK_EN`, when defined:
  - Adds input port `mask` (N bits, after `a`).
  - In scan mode, the loaded channel is the first channel c with `mask[c]`=1, searching circularly from `ptr`.
  - On that load, `ptr`←c+1 mod N. `wrap`←1 when no enabled channel lies above c.
  - If `mask` is all zeros, no load occurs and `valid` follows the no-load rules.
  - Manual mode ignores `mask`.
- When undefined: no `mask` port; scan visits every channel.

## Test plan
- Reset, then manual mode with N=8, W=1, `a`=8'b1010_0110, `ready`=1, `sel_in` swept 0..7 -> `y` equals `a[sel_in]` one cycle later, `valid`=1, `sel_out` matches, `sel_err`=0. Check exhaustively over all 2048 (`a`,`sel_in`) combinations against a behavioural model.
- N=5, W=4, scan mode, `ready`=1, `a`={4'h5,4'h4,4'h3,4'h2,4'h1} -> `y` sequence 1,2,3,4,5,1,… with `sel_out` 0..4,0, and `wrap`=1 only with `y`=5.
- Backpressure, scan mode: drop `ready` for 3 cycles after channel 2 is presented -> `y`/`sel_out`=2 held for 3 cycles. The next accepted sample is channel 3, so no channel is skipped.
- N=5, manual mode, `sel_in`=6 -> `y`=0, `sel_err`=1, `sel_out`=6. The following `sel_in`=1 load clears `sel_err`.
- Assert `rst` for one cycle while `valid`=1, `ready`=0, `ptr`=3 -> next cycle all outputs are 0. The next scan load presents channel 0.
- With `MUX_N_SCAN_MASK_EN`, N=8, `mask`=8'b1001_0010 -> scan order 1,4,7,1 with `wrap` on 7. Setting `mask`=0 -> `valid` falls after the held sample is accepted.
